// File: rtl/accel_pkg.sv
// Shared constants, state encodings and helpers for the ADXL345-to-servo duty generator.
package accel_pkg;

  // ADXL345 register map and configuration values
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATAX0      = 8'h32;
  localparam logic [7:0] CFG_DATA_FORMAT = 8'h00;  // +/-2 g range, 4-wire SPI
  localparam logic [7:0] CFG_POWER_CTL   = 8'h08;  // measure mode

  // SPI command byte fields
  localparam logic [7:0] SPI_READ_BIT  = 8'h80;
  localparam logic [7:0] SPI_MULTI_BIT = 8'h40;
  localparam logic [7:0] CMD_READ_XY   = SPI_READ_BIT | SPI_MULTI_BIT | REG_DATAX0;
  localparam logic [7:0] FILL_BYTE     = 8'h00;

  // Index of the last byte in each frame type (config: addr+data, read: cmd+4 data)
  localparam logic [2:0] CFG_LAST_IDX  = 3'd1;
  localparam logic [2:0] READ_LAST_IDX = 3'd4;

  // Raw-to-duty mapping
  localparam int CLAMP_LIM  = 250;
  localparam int DUTY_SCALE = 200;

  typedef enum logic [2:0] {
    CFG_FMT,
    CFG_PWR,
    IDLE,
    READ,
    MAP
  } state_e;

  // Phases of one chip-select frame
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_GAP,
    PH_SETUP,
    PH_BYTES
  } frame_ph_e;

  // Byte to transmit at position idx of the frame owned by state st
  function automatic logic [7:0] frame_byte(input state_e st, input logic [2:0] idx);
    logic [7:0] b;
    b = FILL_BYTE;
    case (st)
      CFG_FMT: b = (idx == 3'd0) ? REG_DATA_FORMAT : CFG_DATA_FORMAT;
      CFG_PWR: b = (idx == 3'd0) ? REG_POWER_CTL : CFG_POWER_CTL;
      READ:    b = (idx == 3'd0) ? CMD_READ_XY : FILL_BYTE;
      default: b = FILL_BYTE;
    endcase
    return b;
  endfunction

  // Signed 16-bit axis sample -> clamped servo duty count
  function automatic logic [31:0] axis_to_duty(input logic [15:0] raw, input int mid,
                                               input int dmin, input int dmax);
    int v;
    int d;
    v = $signed(raw);
    if (v > CLAMP_LIM) v = CLAMP_LIM;
    else if (v < -CLAMP_LIM) v = -CLAMP_LIM;
    d = mid + v * DUTY_SCALE;
    if (d < dmin) d = dmin;
    else if (d > dmax) d = dmax;
    return 32'(d);
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Single SPI mode-3 byte exchange. SCLK idles high, MOSI changes on falling edges,
// MISO is sampled on rising edges. o_done is asserted in the last clk cycle of the
// trailing half-period, so a start in that same cycle continues with no SCLK stretch.
module spi_byte_xfer
  import accel_pkg::*;
#(
  parameter int SCLK_HALF = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_done,
  output logic [7:0] o_rx
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_phase;   // even = SCLK low half, odd = SCLK high half
  logic [7:0]    r_tx_sr;
  logic [7:0]    r_rx_sr;
  logic          r_sclk;
  logic          r_mosi;

  logic w_half_end;
  logic w_load;

  assign w_half_end = r_busy && (r_cnt == HALF_LAST);
  assign o_done     = w_half_end && (r_phase == 4'd15);
  assign w_load     = i_start && (!r_busy || o_done);

  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_rx   = r_rx_sr;

  // Half-period timer and bit shifter
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b0;
    end else if (w_load) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_phase <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= i_tx[7];
      r_tx_sr <= {i_tx[6:0], 1'b0};
    end else if (o_done) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_half_end) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 4'd1;
      if (!r_phase[0]) begin
        r_sclk  <= 1'b1;
        r_rx_sr <= {r_rx_sr[6:0], i_miso};
      end else begin
        r_sclk  <= 1'b0;
        r_mosi  <= r_tx_sr[7];
        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
      end
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/accel_duty_gen.sv
// Configures an ADXL345 over SPI, reads X/Y at a fixed rate and maps each axis
// to a servo duty count. Owns chip select and frame sequencing; bytes are
// exchanged by spi_byte_xfer.
module accel_duty_gen
  import accel_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SAMPLE_HZ = 100,
  parameter int SCLK_HALF = 25,
  parameter int DUTY_MID  = 75_000,
  parameter int DUTY_MIN  = 25_000,
  parameter int DUTY_MAX  = 125_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] duty_x,
  output logic [31:0] duty_y,
  output logic        duty_valid
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
  localparam logic [31:0]   TICK_LAST = 32'(CLK_FREQ / SAMPLE_HZ - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  frame_ph_e     r_ph;
  logic [CW-1:0] r_ph_cnt;
  logic [2:0]    r_byte_idx;
  logic          r_cs_n;
  logic [31:0]   r_tick_cnt;
  logic [7:0]    r_raw [4];   // X0, X1, Y0, Y1
  logic [31:0]   r_duty_x;
  logic [31:0]   r_duty_y;
  logic          r_duty_valid;

  logic       w_tick;
  logic       w_half_end;
  logic       w_frame_req;
  logic       w_last_byte;
  logic       w_xfer_start;
  logic       w_xfer_done;
  logic       w_frame_done;
  logic [2:0] w_next_idx;
  logic [7:0] w_tx_byte;
  logic [7:0] w_rx_byte;

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_half_end   = (r_ph_cnt == HALF_LAST);
  assign w_frame_req  = (r_ph == PH_IDLE) &&
                        ((r_state == CFG_FMT) || (r_state == CFG_PWR) || (r_state == READ));
  assign w_last_byte  = (r_byte_idx == ((r_state == READ) ? READ_LAST_IDX : CFG_LAST_IDX));
  assign w_frame_done = (r_ph == PH_BYTES) && w_xfer_done && w_last_byte;
  assign w_xfer_start = ((r_ph == PH_SETUP) && w_half_end) ||
                        ((r_ph == PH_BYTES) && w_xfer_done && !w_last_byte);
  assign w_next_idx   = (r_ph == PH_SETUP) ? 3'd0 : r_byte_idx + 3'd1;
  assign w_tx_byte    = frame_byte(r_state, w_next_idx);

  assign spi_cs_n   = r_cs_n;
  assign duty_x     = r_duty_x;
  assign duty_y     = r_duty_y;
  assign duty_valid = r_duty_valid;

  spi_byte_xfer #(
    .SCLK_HALF(SCLK_HALF)
  ) u_xfer (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_xfer_start),
    .i_tx   (w_tx_byte),
    .i_miso (spi_miso),
    .o_sclk (spi_sclk),
    .o_mosi (spi_mosi),
    .o_done (w_xfer_done),
    .o_rx   (w_rx_byte)
  );

  // Free-running sample tick; ticks seen outside IDLE are simply ignored
  always_ff @(posedge clk) begin
    if (!rst)        r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 32'd1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= CFG_FMT;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      CFG_FMT: if (w_frame_done) w_state_nxt = CFG_PWR;
      CFG_PWR: if (w_frame_done) w_state_nxt = IDLE;
      IDLE:    if (w_tick)       w_state_nxt = READ;
      READ:    if (w_frame_done) w_state_nxt = MAP;
      MAP:                       w_state_nxt = IDLE;
      default:                   w_state_nxt = CFG_FMT;
    endcase
  end

  // Frame sequencer: CS-high gap, CS setup, byte chain, CS release after last byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ph       <= PH_IDLE;
      r_ph_cnt   <= '0;
      r_byte_idx <= '0;
      r_cs_n     <= 1'b1;
    end else begin
      case (r_ph)
        PH_IDLE: begin
          if (w_frame_req) begin
            r_ph     <= PH_GAP;
            r_ph_cnt <= '0;
          end
        end
        PH_GAP: begin
          if (w_half_end) begin
            r_ph     <= PH_SETUP;
            r_ph_cnt <= '0;
            r_cs_n   <= 1'b0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        PH_SETUP: begin
          if (w_half_end) begin
            r_ph       <= PH_BYTES;
            r_ph_cnt   <= '0;
            r_byte_idx <= '0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 1'b1;
          end
        end
        PH_BYTES: begin
          if (w_xfer_done) begin
            if (w_last_byte) begin
              r_cs_n <= 1'b1;
              r_ph   <= PH_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
        end
        default: r_ph <= PH_IDLE;
      endcase
    end
  end

  // Capture the four data bytes of a read frame
  always_ff @(posedge clk) begin
    // NOTE: this capture store has no reset; it is fully rewritten by every read
    // frame before MAP consumes it.
    if ((r_state == READ) && (r_ph == PH_BYTES) && w_xfer_done && (r_byte_idx != 3'd0))
      r_raw[2'(r_byte_idx - 3'd1)] <= w_rx_byte;
  end

  // Map both axes in the single MAP cycle and pulse duty_valid with the update
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_duty_x     <= 32'(DUTY_MID);
      r_duty_y     <= 32'(DUTY_MID);
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= (r_state == MAP);
      if (r_state == MAP) begin
        r_duty_x <= axis_to_duty({r_raw[1], r_raw[0]}, DUTY_MID, DUTY_MIN, DUTY_MAX);
        r_duty_y <= axis_to_duty({r_raw[3], r_raw[2]}, DUTY_MID, DUTY_MIN, DUTY_MAX);
      end
    end
  end

endmodule

// File: tb/tb_accel_duty_gen.sv
// Self-checking bench for accel_duty_gen: an ADXL345 slave/monitor records every
// CS frame and duty_valid pulse, and the main sequence compares them against
// frame contents, timing and duty values derived from the sensor data it supplies.
module tb_accel_duty_gen;

  localparam int CLK_FREQ   = 400_000;
  localparam int SAMPLE_HZ  = 100;
  localparam int SCLK_HALF  = 25;
  localparam int TICK_N     = CLK_FREQ / SAMPLE_HZ;
  localparam int DUTY_MID   = 75_000;
  localparam int FRAME_WAIT = 2 * TICK_N + 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_miso = 1'b0;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [31:0] duty_x;
  logic [31:0] duty_y;
  logic        duty_valid;

  always #5 clk = ~clk;

  accel_duty_gen #(
    .CLK_FREQ (CLK_FREQ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .SCLK_HALF(SCLK_HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .duty_x    (duty_x),
    .duty_y    (duty_y),
    .duty_valid(duty_valid)
  );

  typedef struct {
    int          rises;
    logic [39:0] mosi;
    int          setup;
    int          hold;
    bit          period_ok;
    int          fall_cyc;
    int          rise_cyc;
    logic [31:0] dx;
    logic [31:0] dy;
  } frame_t;

  typedef struct {
    int          cyc;
    logic [31:0] x;
    logic [31:0] y;
  } valid_t;

  frame_t frame_q[$];
  valid_t valid_q[$];

  int n_total = 0;
  int n_bad   = 0;

  logic [39:0] slave_resp = '0;  // {dummy, X0, X1, Y0, Y1} shifted out MSB first
  int          last_read_fall = 0;
  logic [31:0] prev_x = 32'(DUTY_MID);
  logic [31:0] prev_y = 32'(DUTY_MID);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  endtask

  function automatic logic [39:0] resp_word(input logic [15:0] x, input logic [15:0] y);
    return {8'h00, x[7:0], x[15:8], y[7:0], y[15:8]};
  endfunction

  // Sensor rule: clamp signed reading to +/-250 counts, 200 duty counts per step
  function automatic int model_duty(input logic [15:0] raw);
    int v;
    v = $signed(raw);
    if (v > 250)  v = 250;
    if (v < -250) v = -250;
    return DUTY_MID + 200 * v;
  endfunction

  // ---------------- slave model and bus monitor (sampled on falling clk) ----------------
  int          cyc = 0;
  bit          prev_cs = 1'b1;
  bit          prev_sclk = 1'b1;
  bit          in_frame = 1'b0;
  bit          m_first;
  bit          m_period_ok;
  int          m_fall_cyc;
  int          m_last_fall;
  int          m_last_rise;
  int          m_setup;
  int          m_rises = 0;
  logic [39:0] m_mosi;
  logic [39:0] m_resp;
  frame_t      m_fr;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      in_frame = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        in_frame    = 1'b1;
        m_fall_cyc  = cyc;
        m_first     = 1'b1;
        m_period_ok = 1'b1;
        m_rises     = 0;
        m_mosi      = '0;
        m_resp      = slave_resp;
        m_setup     = 0;
      end
      if (in_frame && prev_sclk && !spi_sclk) begin
        if (m_first) begin
          m_setup = cyc - m_fall_cyc;
          m_first = 1'b0;
        end else if (cyc - m_last_fall != 2 * SCLK_HALF) begin
          m_period_ok = 1'b0;
        end
        m_last_fall = cyc;
        spi_miso    = m_resp[39];
        m_resp      = {m_resp[38:0], 1'b0};
      end
      if (in_frame && !prev_sclk && spi_sclk) begin
        if (cyc - m_last_fall != SCLK_HALF) m_period_ok = 1'b0;
        m_mosi      = {m_mosi[38:0], spi_mosi};
        m_rises++;
        m_last_rise = cyc;
      end
      if (in_frame && !prev_cs && spi_cs_n) begin
        m_fr.rises     = m_rises;
        m_fr.mosi      = m_mosi;
        m_fr.setup     = m_setup;
        m_fr.hold      = cyc - m_last_rise;
        m_fr.period_ok = m_period_ok;
        m_fr.fall_cyc  = m_fall_cyc;
        m_fr.rise_cyc  = cyc;
        m_fr.dx        = duty_x;
        m_fr.dy        = duty_y;
        frame_q.push_back(m_fr);
        in_frame = 1'b0;
      end
      if (duty_valid) valid_q.push_back('{cyc, duty_x, duty_y});
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  // ---------------- sequence helpers ----------------
  task automatic wait_frame(output frame_t f);
    for (int i = 0; i < FRAME_WAIT && frame_q.size() == 0; i++) @(negedge clk);
    check("frame_arrived", 64'(frame_q.size() != 0), 1);
    if (frame_q.size() == 0) finish_run();
    f = frame_q.pop_front();
  endtask

  task automatic check_timing(input string tag, input frame_t f);
    check({tag, "_cs_setup"}, f.setup, SCLK_HALF);
    check({tag, "_cs_hold"}, f.hold, SCLK_HALF);
    check({tag, "_sclk_period"}, f.period_ok, 1);
  endtask

  task automatic expect_config(input string tag);
    frame_t f0;
    frame_t f1;
    wait_frame(f0);
    check({tag, "_fmt_rises"}, f0.rises, 16);
    check({tag, "_fmt_mosi"}, f0.mosi, 40'h3100);
    check_timing({tag, "_fmt"}, f0);
    wait_frame(f1);
    check({tag, "_pwr_rises"}, f1.rises, 16);
    check({tag, "_pwr_mosi"}, f1.mosi, 40'h2D08);
    check_timing({tag, "_pwr"}, f1);
    check({tag, "_cs_gap_ok"}, 64'((f1.fall_cyc - f0.rise_cyc) >= SCLK_HALF), 1);
    check({tag, "_no_valid"}, valid_q.size(), 0);
    check({tag, "_duty_x"}, duty_x, DUTY_MID);
    check({tag, "_duty_y"}, duty_y, DUTY_MID);
  endtask

  task automatic do_read(input int idx, input logic [15:0] x, input logic [15:0] y,
                         input bit check_spacing);
    frame_t f;
    valid_t v;
    string  tag;
    tag = $sformatf("rd%0d", idx);
    wait_frame(f);
    check({tag, "_rises"}, f.rises, 40);
    check({tag, "_mosi"}, f.mosi, 40'hF2_0000_0000);
    check_timing(tag, f);
    check({tag, "_hold_x"}, f.dx, prev_x);
    check({tag, "_hold_y"}, f.dy, prev_y);
    if (check_spacing) check({tag, "_spacing"}, f.fall_cyc - last_read_fall, TICK_N);
    last_read_fall = f.fall_cyc;
    for (int i = 0; i < 10 && valid_q.size() == 0; i++) @(negedge clk);
    check({tag, "_valid_seen"}, 64'(valid_q.size() != 0), 1);
    if (valid_q.size() == 0) finish_run();
    v = valid_q.pop_front();
    check({tag, "_valid_delay"}, v.cyc - f.rise_cyc, 1);
    check({tag, "_duty_x"}, v.x, model_duty(x));
    check({tag, "_duty_y"}, v.y, model_duty(y));
    repeat (3) @(negedge clk);
    check({tag, "_valid_one_cycle"}, valid_q.size(), 0);
    prev_x = 32'(model_duty(x));
    prev_y = 32'(model_duty(y));
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] vx [8];
  logic [15:0] vy [8];

  initial begin
    int tmp;
    vx[0] = 16'h0000; vy[0] = 16'h0064;
    for (int i = 1; i <= 3; i++) begin
      tmp = int'($urandom_range(600, 0)) - 300;
      vx[i] = 16'(tmp);
      tmp = int'($urandom_range(600, 0)) - 300;
      vy[i] = 16'(tmp);
    end
    for (int i = 4; i <= 5; i++) begin
      vx[i] = 16'($urandom);
      vy[i] = 16'($urandom);
    end
    vx[6] = 16'hFF06; vy[6] = 16'h012C;
    vx[7] = 16'h8000; vy[7] = 16'h7FFF;

    rst = 1'b0;
    slave_resp = resp_word(vx[0], vy[0]);
    repeat (4) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_duty_x", duty_x, DUTY_MID);
    check("rst_duty_y", duty_y, DUTY_MID);
    check("rst_valid", duty_valid, 0);
    rst = 1'b1;

    expect_config("cfg1");

    for (int i = 0; i < 8; i++) begin
      do_read(i, vx[i], vy[i], i > 0);
      if (i < 7) slave_resp = resp_word(vx[i + 1], vy[i + 1]);
    end

    // Reset in the middle of the third data byte of a read frame
    slave_resp = resp_word(16'h1234, 16'h5678);
    for (int i = 0; i < FRAME_WAIT && !(in_frame && m_rises >= 26); i++) @(negedge clk);
    check("abort_point_reached", 64'(in_frame && m_rises >= 26), 1);
    if (!(in_frame && m_rises >= 26)) finish_run();
    rst = 1'b0;
    @(negedge clk);
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 1);
    check("abort_duty_x", duty_x, DUTY_MID);
    check("abort_duty_y", duty_y, DUTY_MID);
    check("abort_valid", duty_valid, 0);
    repeat (3) @(negedge clk);
    frame_q.delete();
    valid_q.delete();
    prev_x = 32'(DUTY_MID);
    prev_y = 32'(DUTY_MID);
    slave_resp = resp_word(16'h0032, 16'hFFCE);
    rst = 1'b1;

    expect_config("cfg2");
    do_read(8, 16'h0032, 16'hFFCE, 1'b0);

    finish_run();
  end

endmodule
